fighter_controller: RTL

//  Per-player fighter FSM: movement, neutral/directional attacks, hit/block stun, health and KO.
//  One instance per player, selected by FACING_LEFT; replaces the separate P1/P2 controllers.
//  Hit and block stun run from their own parametrised timers, not from the opponent's state.

---
 rtl/fighter_controller.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/fighter_controller.sv
// Per-player fighter controller: movement, neutral/directional attacks with recovery buffering,
// hit/block stun on local timers, health tracking and sticky KO. Advances once per video frame.
module fighter_controller #(
    parameter bit         FACING_LEFT  = 1'b0,
    parameter logic [9:0] START_X      = 10'd64,
    parameter logic [9:0] PLAYER_WIDTH = 10'd64,
    parameter logic [9:0] SPEED_FWD    = 10'd3,
    parameter logic [9:0] SPEED_BWD    = 10'd2,
    parameter int         I_START      = 5,
    parameter int         I_ACT        = 2,
    parameter int         I_REC        = 16,
    parameter int         D_START      = 4,
    parameter int         D_ACT        = 3,
    parameter int         D_REC        = 15,
    parameter int         HITSTUN_F    = 14,
    parameter int         BLOCKSTUN_F  = 12,
    parameter int         BUF_F        = 4,
    parameter int         HP_W         = 7,
    parameter int         HIT_DMG      = 10
) (
    input  logic            logic_clk,
    input  logic            reset,
    input  logic            in_left,
    input  logic            in_right,
    input  logic            attack,
    input  logic [9:0]      opp_pos_x,
    input  logic [1:0]      stunmode,
    input  logic [9:0]      screen_left_bound,
    input  logic [9:0]      screen_right_bound,
    output logic [9:0]      player_pos_x,
    output logic [3:0]      player_state,
    output logic            move_flag,
    output logic            attack_flag,
    output logic            is_directional_attack,
    output logic [HP_W-1:0] health,
    output logic            ko
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FWD       = 4'd1,
        S_BWD       = 4'd2,
        S_IATK_ST   = 4'd3,
        S_IATK_ACT  = 4'd4,
        S_IATK_REC  = 4'd5,
        S_DATK_ST   = 4'd6,
        S_DATK_ACT  = 4'd7,
        S_DATK_REC  = 4'd8,
        S_HITSTUN   = 4'd9,
        S_BLOCKSTUN = 4'd10,
        S_KO        = 4'd11
    } state_t;

    localparam logic [5:0] I_ST_LAST  = 6'(I_START - 1);
    localparam logic [5:0] I_ACT_LAST = 6'(I_ACT - 1);
    localparam logic [5:0] I_REC_LAST = 6'(I_REC - 1);
    localparam logic [5:0] I_BUF_FROM = 6'(I_REC - BUF_F);
    localparam logic [5:0] D_ST_LAST  = 6'(D_START - 1);
    localparam logic [5:0] D_ACT_LAST = 6'(D_ACT - 1);
    localparam logic [5:0] D_REC_LAST = 6'(D_REC - 1);
    localparam logic [5:0] D_BUF_FROM = 6'(D_REC - BUF_F);
    localparam logic [5:0] HIT_LAST   = 6'(HITSTUN_F - 1);
    localparam logic [5:0] BLK_LAST   = 6'(BLOCKSTUN_F - 1);
    localparam logic [HP_W-1:0] DMG   = HP_W'(HIT_DMG);

    state_t          state_q, state_d;
    logic [9:0]      x_q, x_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [HP_W-1:0] health_q, health_d;
    logic            buf_q, buf_d;
    logic            buf_dir_q, buf_dir_d;
    logic            reenter;

    // 12-bit arithmetic so sums of three 10-bit terms never wrap.
    logic [11:0] x_w, lb_w, rb_w, opp_w, pw_w, sf_w, sb_w;
    assign x_w   = {2'b00, x_q};
    assign lb_w  = {2'b00, screen_left_bound};
    assign rb_w  = {2'b00, screen_right_bound};
    assign opp_w = {2'b00, opp_pos_x};
    assign pw_w  = {2'b00, PLAYER_WIDTH};
    assign sf_w  = {2'b00, SPEED_FWD};
    assign sb_w  = {2'b00, SPEED_BWD};

    logic fwd_in, bwd_in, dir_any, fwd_legal, bwd_legal;
    logic [9:0] fwd_x, bwd_x;
    assign fwd_in  = FACING_LEFT ? in_left : in_right;
    assign bwd_in  = FACING_LEFT ? in_right : in_left;
    assign dir_any = in_left | in_right;
    assign fwd_legal = FACING_LEFT
        ? ((x_w > lb_w + sf_w) && (x_w > opp_w + pw_w + sf_w))
        : ((x_w + pw_w + sf_w < rb_w) && (x_w + pw_w + sf_w < opp_w));
    assign bwd_legal = FACING_LEFT ? (x_w + pw_w + sb_w < rb_w) : (x_w > lb_w + sb_w);
    assign fwd_x = FACING_LEFT ? x_q - SPEED_FWD : x_q + SPEED_FWD;
    assign bwd_x = FACING_LEFT ? x_q + SPEED_BWD : x_q - SPEED_BWD;

    logic [HP_W-1:0] hp_hit;
    state_t          hit_state;
    assign hp_hit    = (health_q > DMG) ? health_q - DMG : '0;
    assign hit_state = (hp_hit == '0) ? S_KO : S_HITSTUN;

    // A capture on the final recovery frame still counts toward the follow-up attack.
    logic [5:0] rec_last, buf_from;
    logic       cap_now, cap_buf, cap_dir;
    assign rec_last = (state_q == S_IATK_REC) ? I_REC_LAST : D_REC_LAST;
    assign buf_from = (state_q == S_IATK_REC) ? I_BUF_FROM : D_BUF_FROM;
    assign cap_now  = attack && (cnt_q >= buf_from);
    assign cap_buf  = buf_q | cap_now;
    assign cap_dir  = cap_now ? dir_any : buf_dir_q;

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        health_d  = health_q;
        buf_d     = buf_q;
        buf_dir_d = buf_dir_q;
        reenter   = 1'b0;
        case (state_q)
            S_IDLE, S_FWD, S_BWD: begin
                if (stunmode == 2'b01) begin
                    state_d  = hit_state;
                    health_d = hp_hit;
                end else if (stunmode == 2'b10) begin
                    state_d = S_BLOCKSTUN;
                end else if (attack && dir_any) begin
                    state_d = S_DATK_ST;
                end else if (attack) begin
                    state_d = S_IATK_ST;
                end else if (bwd_in && bwd_legal) begin
                    state_d = S_BWD;
                    x_d     = bwd_x;
                end else if (fwd_in && fwd_legal) begin
                    state_d = S_FWD;
                    x_d     = fwd_x;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_IATK_ST:  if (cnt_q == I_ST_LAST)  state_d = S_IATK_ACT;
            S_IATK_ACT: if (cnt_q == I_ACT_LAST) state_d = S_IATK_REC;
            S_DATK_ST:  if (cnt_q == D_ST_LAST)  state_d = S_DATK_ACT;
            S_DATK_ACT: if (cnt_q == D_ACT_LAST) state_d = S_DATK_REC;
            S_IATK_REC, S_DATK_REC: begin
                if (stunmode == 2'b01) begin
                    state_d   = hit_state;
                    health_d  = hp_hit;
                    buf_d     = 1'b0;
                    buf_dir_d = 1'b0;
                end else if (cnt_q == rec_last) begin
                    state_d   = cap_buf ? (cap_dir ? S_DATK_ST : S_IATK_ST) : S_IDLE;
                    buf_d     = 1'b0;
                    buf_dir_d = 1'b0;
                end else if (cap_now) begin
                    buf_d     = 1'b1;
                    buf_dir_d = dir_any;
                end
            end
            S_HITSTUN: begin
                if (stunmode == 2'b01) begin
                    state_d  = hit_state;
                    health_d = hp_hit;
                    reenter  = 1'b1;
                end else if (cnt_q == HIT_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_BLOCKSTUN: begin
                if (stunmode == 2'b01) begin
                    state_d  = hit_state;
                    health_d = hp_hit;
                end else if (stunmode == 2'b10) begin
                    reenter = 1'b1;
                end else if (cnt_q == BLK_LAST) begin
                    state_d = S_IDLE;
                end
            end
            S_KO: state_d = S_KO;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if ((state_d != state_q) || reenter) cnt_d = 6'd0;
        else if (cnt_q != 6'd63)             cnt_d = cnt_q + 6'd1;
    end

    always_ff @(posedge logic_clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            x_q       <= START_X;
            cnt_q     <= 6'd0;
            health_q  <= '1;
            buf_q     <= 1'b0;
            buf_dir_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            cnt_q     <= cnt_d;
            health_q  <= health_d;
            buf_q     <= buf_d;
            buf_dir_q <= buf_dir_d;
        end
    end

    assign player_pos_x          = x_q;
    assign player_state          = state_q;
    assign move_flag             = (state_q == S_FWD) || (state_q == S_BWD);
    assign attack_flag           = (state_q == S_IATK_ACT);
    assign is_directional_attack = (state_q == S_DATK_ACT);
    assign health                = health_q;
    assign ko                    = (state_q == S_KO);

endmodule
